kb_scan_handler: RTL and testbench

- Sits between the PS/2 byte receiver and the scan-code-to-ASCII converter.
- Consumes raw PS/2 set-2 bytes and tracks the break prefix F0 and the extended prefix E0.
- Maintains left/right shift and caps-lock state.
- Queues each non-modifier key press as a {letter_case, scan_code} entry in a small show-ahead FIFO. The converter and its consumer pop from that FIFO.

---
 rtl/kb_pkg.sv | 33 +++
 rtl/kb_scan_handler_if.sv | 37 +++
 rtl/key_fifo.sv | 58 +++++
 rtl/kb_scan_handler.sv | 128 ++++++++++++
 tb/tb_kb_scan_handler.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/kb_pkg.sv
// Shared constants and types for the PS/2 scan-code handler.
// Holds the set-2 prefix/modifier codes, the FSM state type and the layout
// of one queued key entry.
package kb_pkg;

    localparam logic [7:0] BRK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE = 8'hE0;
    localparam logic [7:0] LSHIFT   = 8'h12;
    localparam logic [7:0] RSHIFT   = 8'h59;
    localparam logic [7:0] CAPS     = 8'h58;

    localparam int KEY_W = 9;

    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } kb_state_t;

    typedef struct packed {
        logic       letter_case;
        logic [7:0] scan_code;
    } key_entry_t;

    function automatic key_entry_t makeEntry(input logic upper, input logic [7:0] code);
        key_entry_t e;
        e.letter_case = upper;
        e.scan_code   = code;
        return e;
    endfunction

endpackage

// File: rtl/kb_scan_handler_if.sv
// Bundle of the byte-receiver side and the key-consumer side of the handler.
// The slave modport is the handler itself; the master modport is whoever
// feeds it bytes and pops keys.
interface kb_scan_handler_if;

    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       rd_key;
    logic [7:0] scan_code;
    logic       letter_case;
    logic       key_empty;
    logic       key_full;
    logic       overflow;

    modport master (
        output rx_done_tick,
        output rx_data,
        output rd_key,
        input  scan_code,
        input  letter_case,
        input  key_empty,
        input  key_full,
        input  overflow
    );

    modport slave (
        input  rx_done_tick,
        input  rx_data,
        input  rd_key,
        output scan_code,
        output letter_case,
        output key_empty,
        output key_full,
        output overflow
    );

endinterface

// File: rtl/key_fifo.sv
// Small show-ahead FIFO for queued key entries.
// Pointers carry one extra MSB so full and empty can be told apart when the
// low address bits match. The head entry reads as zero while empty.
module key_fifo #(
    parameter int WIDTH   = 9,
    parameter int FIFO_AW = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] w_data,
    output logic [WIDTH-1:0] r_data,
    output logic             empty,
    output logic             full
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [FIFO_AW:0] r_wrPtr;
    logic [FIFO_AW:0] r_rdPtr;
    logic             w_doWrite;
    logic             w_doRead;

    assign empty = (r_wrPtr == r_rdPtr);
    assign full  = (r_wrPtr[FIFO_AW] != r_rdPtr[FIFO_AW]) &&
                   (r_wrPtr[FIFO_AW-1:0] == r_rdPtr[FIFO_AW-1:0]);

    assign w_doRead  = rd && !empty;
    assign w_doWrite = wr && (!full || w_doRead);

    assign r_data = empty ? '0 : r_mem[r_rdPtr[FIFO_AW-1:0]];

    // Advance each pointer only when its operation is legal; a write into a
    // full FIFO is allowed only when the head is leaving in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doWrite) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doRead) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

    // Storage needs no reset because the output is masked while empty.
    always_ff @(posedge clk) begin
        if (w_doWrite) begin
            r_mem[r_wrPtr[FIFO_AW-1:0]] <= w_data;
        end
    end

endmodule

// File: rtl/kb_scan_handler.sv
// PS/2 set-2 scan-code handler.
// Strips break and extended prefixes, tracks both shift keys and caps lock,
// and queues every ordinary key press together with its case so the
// ASCII converter can consume them at its own pace.
module kb_scan_handler
    import kb_pkg::*;
#(
    parameter int FIFO_AW = 2
) (
    input  logic                clk,
    input  logic                reset,
    kb_scan_handler_if.slave    kb
);

    kb_state_t        r_state;
    kb_state_t        w_stateNext;
    logic             r_shiftL;
    logic             r_shiftR;
    logic             r_capsLock;
    logic             r_capsHeld;
    logic             w_shiftLNext;
    logic             w_shiftRNext;
    logic             w_capsLockNext;
    logic             w_capsHeldNext;
    logic             w_push;
    key_entry_t       w_pushEntry;
    key_entry_t       w_headEntry;
    logic [KEY_W-1:0] w_pushBits;
    logic [KEY_W-1:0] w_headBits;
    logic             w_fifoEmpty;
    logic             w_fifoFull;

    // Register the prefix-tracking state and the modifier flags; all the
    // decisions about what changes live in the combinational block below.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= WAIT;
            r_shiftL   <= 1'b0;
            r_shiftR   <= 1'b0;
            r_capsLock <= 1'b0;
            r_capsHeld <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_shiftL   <= w_shiftLNext;
            r_shiftR   <= w_shiftRNext;
            r_capsLock <= w_capsLockNext;
            r_capsHeld <= w_capsHeldNext;
        end
    end

    // Decode one received byte: prefixes move the FSM, modifiers update the
    // flags, and any other make code becomes a push with the case it has now.
    always_comb begin
        w_stateNext    = r_state;
        w_shiftLNext   = r_shiftL;
        w_shiftRNext   = r_shiftR;
        w_capsLockNext = r_capsLock;
        w_capsHeldNext = r_capsHeld;
        w_push         = 1'b0;
        w_pushEntry    = makeEntry((r_shiftL | r_shiftR) ^ r_capsLock, kb.rx_data);

        if (kb.rx_done_tick) begin
            case (r_state)
                WAIT: begin
                    if (kb.rx_data == EXT_CODE) begin
                        w_stateNext = EXT;
                    end else if (kb.rx_data == BRK_CODE) begin
                        w_stateNext = BRK;
                    end else if (kb.rx_data == LSHIFT) begin
                        w_shiftLNext = 1'b1;
                    end else if (kb.rx_data == RSHIFT) begin
                        w_shiftRNext = 1'b1;
                    end else if (kb.rx_data == CAPS) begin
                        if (!r_capsHeld) begin
                            w_capsLockNext = ~r_capsLock;
                        end
                        w_capsHeldNext = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                end
                BRK: begin
                    if (kb.rx_data == LSHIFT) begin
                        w_shiftLNext = 1'b0;
                    end else if (kb.rx_data == RSHIFT) begin
                        w_shiftRNext = 1'b0;
                    end else if (kb.rx_data == CAPS) begin
                        w_capsHeldNext = 1'b0;
                    end
                    w_stateNext = WAIT;
                end
                EXT: begin
                    w_stateNext = (kb.rx_data == BRK_CODE) ? EXT_BRK : WAIT;
                end
                EXT_BRK: begin
                    w_stateNext = WAIT;
                end
                default: begin
                    w_stateNext = WAIT;
                end
            endcase
        end
    end

    assign w_pushBits = w_pushEntry;

    key_fifo #(
        .WIDTH   (KEY_W),
        .FIFO_AW (FIFO_AW)
    ) u_keyFifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (w_push),
        .rd     (kb.rd_key),
        .w_data (w_pushBits),
        .r_data (w_headBits),
        .empty  (w_fifoEmpty),
        .full   (w_fifoFull)
    );

    assign w_headEntry    = key_entry_t'(w_headBits);
    assign kb.scan_code   = w_headEntry.scan_code;
    assign kb.letter_case = w_headEntry.letter_case;
    assign kb.key_empty   = w_fifoEmpty;
    assign kb.key_full    = w_fifoFull;
    assign kb.overflow    = w_push && w_fifoFull && !kb.rd_key && !reset;

endmodule

// File: tb/tb_kb_scan_handler.sv
// Bench for kb_scan_handler: a directed vector table, a reset-mid-sequence
// sequence, and random key events checked against an event-level model.
module tb_kb_scan_handler;
    import kb_pkg::*;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    kb_scan_handler_if kbIf();

    kb_scan_handler #(.FIFO_AW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .kb    (kbIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       tick;
        logic [7:0] data;
        logic       rd;
        logic [7:0] expScan;
        logic       expCase;
        logic       expEmpty;
        logic       expFull;
        logic       expOvf;
    } vec_t;

    typedef enum int {A_NONE, A_PRESS, A_LON, A_LOFF, A_RON, A_ROFF, A_CON, A_COFF} act_t;

    typedef struct {
        logic [7:0] b;
        act_t       a;
    } tb_byte_t;

    vec_t        vecs[$];
    tb_byte_t    bq[$];
    logic [8:0]  mq[$];
    logic        mL, mR, mC, mH;

    task automatic addRow(input logic tick, input logic [7:0] data, input logic rd,
                          input logic [7:0] s, input logic c, input logic e,
                          input logic f, input logic o);
        vec_t v;
        v.tick = tick; v.data = data; v.rd = rd;
        v.expScan = s; v.expCase = c; v.expEmpty = e; v.expFull = f; v.expOvf = o;
        vecs.push_back(v);
    endtask

    task automatic tk(input logic [7:0] d, input logic [7:0] s, input logic c,
                      input logic e, input logic f);
        addRow(1'b1, d, 1'b0, s, c, e, f, 1'b0);
    endtask

    task automatic id(input logic rd, input logic [7:0] s, input logic c,
                      input logic e, input logic f);
        addRow(1'b0, 8'h00, rd, s, c, e, f, 1'b0);
    endtask

    task automatic tkE(input logic [7:0] d);
        tk(d, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic applyStimulus(input logic tick, input logic [7:0] data, input logic rd);
        kbIf.rx_done_tick = tick;
        kbIf.rx_data      = data;
        kbIf.rd_key       = rd;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] s, input logic c,
                               input logic e, input logic f, input logic o);
        total++;
        if ({kbIf.scan_code, kbIf.letter_case, kbIf.key_empty, kbIf.key_full, kbIf.overflow}
            !== {s, c, e, f, o}) begin
            bad++;
            $display("[TB] FAIL %s: got scan=%h case=%b empty=%b full=%b ovf=%b, want scan=%h case=%b empty=%b full=%b ovf=%b",
                     name, kbIf.scan_code, kbIf.letter_case, kbIf.key_empty, kbIf.key_full,
                     kbIf.overflow, s, c, e, f, o);
        end
    endtask

    function automatic logic [7:0] normalKey();
        logic [7:0] k;
        do begin
            k = 8'($urandom_range(1, 127));
        end while (k == LSHIFT || k == RSHIFT || k == CAPS);
        return k;
    endfunction

    task automatic addByte(input logic [7:0] b, input act_t a);
        tb_byte_t t;
        t.b = b;
        t.a = a;
        bq.push_back(t);
    endtask

    task automatic genEvent();
        int r;
        logic [7:0] k;
        r = $urandom_range(0, 9);
        k = normalKey();
        case (r)
            0, 1, 2, 3: addByte(k, A_PRESS);
            4: begin addByte(BRK_CODE, A_NONE); addByte(k, A_NONE); end
            5: begin
                addByte(EXT_CODE, A_NONE);
                addByte(($urandom_range(0, 1) == 0) ? LSHIFT : k, A_NONE);
            end
            6: begin addByte(EXT_CODE, A_NONE); addByte(BRK_CODE, A_NONE); addByte(k, A_NONE); end
            7: begin
                case ($urandom_range(0, 3))
                    0: addByte(LSHIFT, A_LON);
                    1: addByte(RSHIFT, A_RON);
                    2: begin addByte(BRK_CODE, A_NONE); addByte(LSHIFT, A_LOFF); end
                    default: begin addByte(BRK_CODE, A_NONE); addByte(RSHIFT, A_ROFF); end
                endcase
            end
            8: addByte(CAPS, A_CON);
            default: begin addByte(BRK_CODE, A_NONE); addByte(CAPS, A_COFF); end
        endcase
    endtask

    initial begin
        logic       tick, rd, willPop, eOvf;
        logic [8:0] head;
        tb_byte_t   cur;
        int         evCount;

        reset = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;

        tk(8'h1C, 8'h00, 0, 1, 0);
        tk(8'hF0, 8'h1C, 0, 0, 0);
        tk(8'h1C, 8'h1C, 0, 0, 0);
        id(1, 8'h1C, 0, 0, 0);
        id(1, 8'h00, 0, 1, 0);
        id(0, 8'h00, 0, 1, 0);

        tkE(8'h12); tkE(8'h33);
        tk(8'hF0, 8'h33, 1, 0, 0); tk(8'h33, 8'h33, 1, 0, 0);
        tk(8'hF0, 8'h33, 1, 0, 0); tk(8'h12, 8'h33, 1, 0, 0);
        tk(8'h33, 8'h33, 1, 0, 0);
        id(1, 8'h33, 1, 0, 0);
        id(1, 8'h33, 0, 0, 0);
        id(0, 8'h00, 0, 1, 0);

        tkE(8'h58); tkE(8'h58); tkE(8'hF0); tkE(8'h58); tkE(8'h1C);
        tk(8'h12, 8'h1C, 1, 0, 0); tk(8'h1C, 8'h1C, 1, 0, 0);
        tk(8'hF0, 8'h1C, 1, 0, 0); tk(8'h12, 8'h1C, 1, 0, 0);
        id(1, 8'h1C, 1, 0, 0);
        id(1, 8'h1C, 0, 0, 0);
        tkE(8'h58); tkE(8'hF0); tkE(8'h58);

        tkE(8'hE0); tkE(8'h75); tkE(8'hE0); tkE(8'hF0); tkE(8'h75);
        tkE(8'hF0); tkE(8'h45); tkE(8'h45);
        id(0, 8'h45, 0, 0, 0);
        id(1, 8'h45, 0, 0, 0);
        id(0, 8'h00, 0, 1, 0);

        tkE(8'h16);
        tk(8'h1E, 8'h16, 0, 0, 0); tk(8'h26, 8'h16, 0, 0, 0); tk(8'h25, 8'h16, 0, 0, 0);
        id(0, 8'h16, 0, 0, 1);
        addRow(1, 8'h2E, 0, 8'h16, 0, 0, 1, 1);
        id(0, 8'h16, 0, 0, 1);
        addRow(1, 8'h36, 1, 8'h16, 0, 0, 1, 0);
        id(1, 8'h1E, 0, 0, 1);
        id(1, 8'h26, 0, 0, 0);
        id(1, 8'h25, 0, 0, 0);
        id(1, 8'h36, 0, 0, 0);
        id(0, 8'h00, 0, 1, 0);

        addRow(1, 8'h4E, 1, 8'h00, 0, 1, 0, 0);
        id(0, 8'h4E, 0, 0, 0);
        id(1, 8'h4E, 0, 0, 0);
        id(0, 8'h00, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].tick, vecs[i].data, vecs[i].rd);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), vecs[i].expScan, vecs[i].expCase,
                        vecs[i].expEmpty, vecs[i].expFull, vecs[i].expOvf);
            @(posedge clk); #1;
        end

        applyStimulus(1'b1, 8'h12, 1'b0); @(posedge clk); #1;
        applyStimulus(1'b1, 8'h1C, 1'b0); @(posedge clk); #1;
        applyStimulus(1'b1, 8'hF0, 1'b0); @(posedge clk); #1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("preReset", 8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("asyncReset", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        applyStimulus(1'b1, 8'h29, 1'b0);
        @(negedge clk);
        checkOutput("postResetTick", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        checkOutput("postResetEntry", 8'h29, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("postResetDrained", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;

        mL = 1'b0; mR = 1'b0; mC = 1'b0; mH = 1'b0;
        evCount = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (bq.size() == 0 && evCount < 400) begin
                genEvent();
                evCount++;
            end
            tick = (bq.size() > 0) && ($urandom_range(0, 3) != 0);
            rd   = ($urandom_range(0, 3) == 0);
            if (tick) begin
                cur = bq[0];
            end else begin
                cur.b = 8'($urandom_range(0, 255));
                cur.a = A_NONE;
            end
            applyStimulus(tick, cur.b, rd);

            head    = (mq.size() > 0) ? mq[0] : 9'h000;
            willPop = rd && (mq.size() > 0);
            eOvf    = tick && (cur.a == A_PRESS) && (mq.size() == 4) && !willPop;
            @(negedge clk);
            checkOutput($sformatf("rand%0d", cyc), head[7:0], head[8],
                        mq.size() == 0, mq.size() == 4, eOvf);

            if (willPop) begin
                void'(mq.pop_front());
            end
            if (tick) begin
                case (cur.a)
                    A_PRESS: if (!eOvf) mq.push_back({(mL | mR) ^ mC, cur.b});
                    A_LON:   mL = 1'b1;
                    A_LOFF:  mL = 1'b0;
                    A_RON:   mR = 1'b1;
                    A_ROFF:  mR = 1'b0;
                    A_CON:   begin if (!mH) mC = ~mC; mH = 1'b1; end
                    A_COFF:  mH = 1'b0;
                    default: ;
                endcase
                void'(bq.pop_front());
            end
            @(posedge clk); #1;
        end

        total++;
        if (evCount < 400 || bq.size() != 0) begin
            bad++;
            $display("[TB] FAIL randomBudget: got events=%0d pending=%0d, want events=400 pending=0",
                     evCount, bq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
